// File: rtl/q_pulse_monitor.sv
// q_pulse_monitor: synchronises, debounces and edge-detects a single-bit level and keeps a
// saturating count of accepted rises. Define QMON_FALL_CNT_EN to add a matching fall counter.
module q_pulse_monitor #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_q,
    input  logic             in_en,
    input  logic             in_clr,
    output logic             out_level,
    output logic             out_rise,
    output logic             out_fall,
    output logic [CNT_W-1:0] out_count,
    output logic             out_sat
`ifdef QMON_FALL_CNT_EN
    ,
    output logic [CNT_W-1:0] out_fall_count
`endif
);

    localparam int               TW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [TW-1:0]    T_ONE   = TW'(1);
    localparam logic [TW-1:0]    T_LAST  = TW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {ST_LO, PEND_HI, ST_HI, PEND_LO} state_t;

    logic [SYNC_STAGES-1:0] sync_reg, sync_next;
    logic                   s;
    state_t                 state_reg, state_next;
    logic [TW-1:0]          timer_reg, timer_next;
    logic                   accept_rise, accept_fall;
    logic                   level_reg, rise_reg, fall_reg, sat_reg;
    logic [CNT_W-1:0]       count_reg, count_next;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sync_next[gi] = in_q;
            end else begin : g_chain
                assign sync_next[gi] = sync_reg[gi-1];
            end
        end
    endgenerate

    assign s = sync_reg[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg  <= '0;
            state_reg <= ST_LO;
            timer_reg <= '0;
        end else begin
            sync_reg  <= sync_next;
            state_reg <= state_next;
            timer_reg <= timer_next;
        end
    end

    // Timer counts consecutive samples already seen at the candidate level.
    always_comb begin
        state_next  = state_reg;
        timer_next  = timer_reg;
        accept_rise = 1'b0;
        accept_fall = 1'b0;
        case (state_reg)
            ST_LO: begin
                if (s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_next  = ST_HI;
                        accept_rise = 1'b1;
                        timer_next  = '0;
                    end else begin
                        state_next = PEND_HI;
                        timer_next = T_ONE;
                    end
                end
            end
            PEND_HI: begin
                if (!s) begin
                    state_next = ST_LO;
                    timer_next = '0;
                end else if (timer_reg == T_LAST) begin
                    state_next  = ST_HI;
                    accept_rise = 1'b1;
                    timer_next  = '0;
                end else begin
                    timer_next = timer_reg + T_ONE;
                end
            end
            ST_HI: begin
                if (!s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_next  = ST_LO;
                        accept_fall = 1'b1;
                        timer_next  = '0;
                    end else begin
                        state_next = PEND_LO;
                        timer_next = T_ONE;
                    end
                end
            end
            PEND_LO: begin
                if (s) begin
                    state_next = ST_HI;
                    timer_next = '0;
                end else if (timer_reg == T_LAST) begin
                    state_next  = ST_LO;
                    accept_fall = 1'b1;
                    timer_next  = '0;
                end else begin
                    timer_next = timer_reg + T_ONE;
                end
            end
            default: begin
                state_next = ST_LO;
                timer_next = '0;
            end
        endcase
    end

    // Clear wins over a simultaneous accepted rise; the pulse itself is unaffected.
    always_comb begin
        count_next = count_reg;
        if (in_clr) begin
            count_next = '0;
        end else if (accept_rise && in_en && (count_reg != CNT_MAX)) begin
            count_next = count_reg + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_reg <= 1'b0;
            rise_reg  <= 1'b0;
            fall_reg  <= 1'b0;
            count_reg <= '0;
            sat_reg   <= 1'b0;
        end else begin
            if (accept_rise) begin
                level_reg <= 1'b1;
            end else if (accept_fall) begin
                level_reg <= 1'b0;
            end
            rise_reg  <= accept_rise;
            fall_reg  <= accept_fall;
            count_reg <= count_next;
            sat_reg   <= (count_next == CNT_MAX);
        end
    end

    assign out_level = level_reg;
    assign out_rise  = rise_reg;
    assign out_fall  = fall_reg;
    assign out_count = count_reg;
    assign out_sat   = sat_reg;

`ifdef QMON_FALL_CNT_EN
    logic [CNT_W-1:0] fall_count_reg, fall_count_next;

    always_comb begin
        fall_count_next = fall_count_reg;
        if (in_clr) begin
            fall_count_next = '0;
        end else if (accept_fall && in_en && (fall_count_reg != CNT_MAX)) begin
            fall_count_next = fall_count_reg + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fall_count_reg <= '0;
        end else begin
            fall_count_reg <= fall_count_next;
        end
    end

    assign out_fall_count = fall_count_reg;
`endif

endmodule

// File: tb/tb_q_pulse_monitor.sv
// Bench for q_pulse_monitor: directed scenarios plus randomized stimulus checked against a
// window-based reference model. Fall-counter checks run only when QMON_FALL_CNT_EN is defined.
module tb_q_pulse_monitor;

    localparam int S    = 2;
    localparam int D    = 4;
    localparam int W    = 8;
    localparam int MAXC = 255;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_q = 1'b0;
    logic         in_en = 1'b1;
    logic         in_clr = 1'b0;
    logic         out_level, out_rise, out_fall, out_sat;
    logic [W-1:0] out_count;
`ifdef QMON_FALL_CNT_EN
    logic [W-1:0] out_fall_count;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit dl_m[$];
    bit win_m[$];
    bit level_m, rise_m, fall_m, sat_m;
    int count_m, fcount_m;

    q_pulse_monitor #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .CNT_W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_q      (in_q),
        .in_en     (in_en),
        .in_clr    (in_clr),
        .out_level (out_level),
        .out_rise  (out_rise),
        .out_fall  (out_fall),
        .out_count (out_count),
        .out_sat   (out_sat)
`ifdef QMON_FALL_CNT_EN
        ,
        .out_fall_count (out_fall_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        dl_m.delete();
        for (int i = 0; i < S; i++) dl_m.push_back(1'b0);
        win_m.delete();
        level_m  = 1'b0;
        rise_m   = 1'b0;
        fall_m   = 1'b0;
        sat_m    = 1'b0;
        count_m  = 0;
        fcount_m = 0;
    endtask

    // A level is accepted when the last D synchronised samples all differ from the current level.
    task automatic model_edge();
        bit s, flip;
        s = dl_m.pop_front();
        dl_m.push_back(in_q);
        win_m.push_back(s);
        if (win_m.size() > D) void'(win_m.pop_front());
        flip = (win_m.size() == D);
        foreach (win_m[i]) if (win_m[i] == level_m) flip = 1'b0;
        rise_m = flip && !level_m;
        fall_m = flip && level_m;
        if (flip) level_m = !level_m;
        if (in_clr) count_m = 0;
        else if (rise_m && in_en) count_m = (count_m < MAXC) ? count_m + 1 : MAXC;
        sat_m = (count_m == MAXC);
        if (in_clr) fcount_m = 0;
        else if (fall_m && in_en) fcount_m = (fcount_m < MAXC) ? fcount_m + 1 : MAXC;
    endtask

    task automatic step(input logic q, input logic en, input logic clr);
        @(negedge clk);
        in_q   = q;
        in_en  = en;
        in_clr = clr;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({out_level, out_rise, out_fall, out_sat, out_count} !== 12'd0) begin
            errors++;
            $display("FAIL reset_hold got lvl=%b r=%b f=%b sat=%b cnt=%0d required all 0",
                     out_level, out_rise, out_fall, out_sat, out_count);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step(1'b0, 1'b1, 1'b0);
            checks++;
            if ({out_level, out_rise, out_fall, out_sat, out_count} !== 12'd0) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d got lvl=%b r=%b f=%b sat=%b cnt=%0d required all 0",
                         k, out_level, out_rise, out_fall, out_sat, out_count);
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_rise_latency();
        for (int k = 1; k <= 10; k++) begin
            step(1'b1, 1'b1, 1'b0);
            checks++;
            if (out_level !== (k >= 6) || out_rise !== (k == 6)) begin
                errors++;
                $display("FAIL rise_latency edge=%0d got lvl=%b rise=%b required lvl=%b rise=%b",
                         k, out_level, out_rise, k >= 6, k == 6);
            end
        end
        checks++;
        if (out_count !== 8'd1) begin
            errors++;
            $display("FAIL rise_count got %0d required 1", out_count);
        end
        $display("test_rise_latency done");
    endtask

    task automatic test_fall_and_glitch();
        for (int k = 1; k <= 10; k++) begin
            step(1'b0, 1'b1, 1'b0);
            checks++;
            if (out_level !== (k < 6) || out_fall !== (k == 6) || out_rise !== 1'b0) begin
                errors++;
                $display("FAIL fall_latency edge=%0d got lvl=%b fall=%b rise=%b required lvl=%b fall=%b rise=0",
                         k, out_level, out_fall, out_rise, k < 6, k == 6);
            end
        end
        for (int k = 1; k <= 13; k++) begin
            step((k <= 3), 1'b1, 1'b0);
            checks++;
            if (out_level !== 1'b0 || out_rise !== 1'b0 || out_fall !== 1'b0) begin
                errors++;
                $display("FAIL glitch cyc=%0d got lvl=%b rise=%b fall=%b required 0 0 0",
                         k, out_level, out_rise, out_fall);
            end
        end
        checks++;
        if (out_count !== 8'd1) begin
            errors++;
            $display("FAIL glitch_count got %0d required 1", out_count);
        end
        $display("test_fall_and_glitch done");
    endtask

    task automatic test_saturation();
        step(1'b0, 1'b1, 1'b1);
        checks++;
        if (out_count !== 8'd0 || out_sat !== 1'b0) begin
            errors++;
            $display("FAIL sat_clear got cnt=%0d sat=%b required 0 0", out_count, out_sat);
        end
        for (int p = 0; p < 300; p++) begin
            for (int c = 0; c < 16; c++) begin
                step((c < 8), 1'b1, 1'b0);
                checks++;
                if (out_count !== W'(count_m) || out_sat !== sat_m || out_rise !== rise_m) begin
                    errors++;
                    $display("FAIL sat_track pulse=%0d got cnt=%0d sat=%b rise=%b required cnt=%0d sat=%b rise=%b",
                             p, out_count, out_sat, out_rise, count_m, sat_m, rise_m);
                end
            end
        end
        checks++;
        if (out_count !== 8'd255 || out_sat !== 1'b1) begin
            errors++;
            $display("FAIL sat_final got cnt=%0d sat=%b required 255 1", out_count, out_sat);
        end
        $display("test_saturation done count=%0d", out_count);
    endtask

    task automatic test_clr_en();
        for (int k = 1; k <= 6; k++) step(1'b1, 1'b1, (k == 6));
        checks++;
        if (out_rise !== 1'b1 || out_count !== 8'd0 || out_sat !== 1'b0) begin
            errors++;
            $display("FAIL clr_on_accept got rise=%b cnt=%0d sat=%b required 1 0 0",
                     out_rise, out_count, out_sat);
        end
        step(1'b1, 1'b1, 1'b0);
        checks++;
        if (out_rise !== 1'b0 || out_count !== 8'd0) begin
            errors++;
            $display("FAIL clr_after got rise=%b cnt=%0d required 0 0", out_rise, out_count);
        end
        repeat (8) step(1'b0, 1'b1, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, 1'b0, 1'b0);
            checks++;
            if (out_rise !== (k == 6) || out_count !== 8'd0) begin
                errors++;
                $display("FAIL en_low edge=%0d got rise=%b cnt=%0d required rise=%b cnt=0",
                         k, out_rise, out_count, k == 6);
            end
        end
        $display("test_clr_en done");
    endtask

    task automatic test_random();
        logic q = 1'b1;
        int   n = 0;
        int   run;
        while (n < 3000) begin
            run = $urandom_range(1, 10);
            q   = ~q;
            for (int r = 0; r < run; r++) begin
                step(q, ($urandom_range(0, 3) != 0), ($urandom_range(0, 39) == 0));
                n++;
                checks++;
                if (out_level !== level_m || out_rise !== rise_m || out_fall !== fall_m) begin
                    errors++;
                    $display("FAIL rnd_edge cyc=%0d got lvl=%b r=%b f=%b required lvl=%b r=%b f=%b",
                             n, out_level, out_rise, out_fall, level_m, rise_m, fall_m);
                end
                checks++;
                if (out_count !== W'(count_m) || out_sat !== sat_m) begin
                    errors++;
                    $display("FAIL rnd_count cyc=%0d got cnt=%0d sat=%b required cnt=%0d sat=%b",
                             n, out_count, out_sat, count_m, sat_m);
                end
`ifdef QMON_FALL_CNT_EN
                checks++;
                if (out_fall_count !== W'(fcount_m)) begin
                    errors++;
                    $display("FAIL rnd_fall_count cyc=%0d got %0d required %0d", n, out_fall_count, fcount_m);
                end
`endif
            end
        end
        $display("test_random done cycles=%0d", n);
    endtask

    task automatic test_reset_mid();
        repeat (8) step(1'b0, 1'b1, 1'b0);
        repeat (8) step(1'b1, 1'b1, 1'b0);
        repeat (8) step(1'b0, 1'b1, 1'b0);
        checks++;
        if (out_count !== W'(count_m) || out_count === 8'd0) begin
            errors++;
            $display("FAIL pre_reset_count got %0d required %0d (nonzero)", out_count, count_m);
        end
        repeat (3) step(1'b1, 1'b1, 1'b0);
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({out_level, out_rise, out_fall, out_sat, out_count} !== 12'd0) begin
            errors++;
            $display("FAIL async_reset got lvl=%b r=%b f=%b sat=%b cnt=%0d required all 0",
                     out_level, out_rise, out_fall, out_sat, out_count);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step(1'b1, 1'b1, 1'b0);
            checks++;
            if (out_rise !== (k == 6) || out_level !== (k >= 6) || out_fall !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_rise edge=%0d got rise=%b lvl=%b fall=%b required rise=%b lvl=%b fall=0",
                         k, out_rise, out_level, out_fall, k == 6, k >= 6);
            end
        end
        checks++;
        if (out_count !== 8'd1) begin
            errors++;
            $display("FAIL post_reset_count got %0d required 1", out_count);
        end
        $display("test_reset_mid done");
    endtask

`ifdef QMON_FALL_CNT_EN
    task automatic test_fall_count();
        for (int p = 0; p < 3; p++) begin
            repeat (8) step(1'b0, 1'b1, 1'b0);
            repeat (8) step(1'b1, 1'b1, 1'b0);
        end
        checks++;
        if (out_fall_count !== 8'd3) begin
            errors++;
            $display("FAIL fall_count got %0d required 3", out_fall_count);
        end
        $display("test_fall_count done");
    endtask
`endif

    initial begin
        test_reset();
        test_rise_latency();
        test_fall_and_glitch();
        test_saturation();
        test_clr_en();
        test_random();
        test_reset_mid();
`ifdef QMON_FALL_CNT_EN
        test_fall_count();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
